// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder/subtractor: one 4-bit slice reused LSB-first,
// with registered carry between nibbles and valid/ready on both sides.

module fulladder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_chk
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0] slice_a, slice_b, slice_s;
  logic       slice_co;
  logic       last_nib;

  assign slice_a  = a_q[4*cnt_q +: 4];
  assign slice_b  = b_q[4*cnt_q +: 4];
  assign last_nib = (cnt_q == CW'(NIB - 1));

  fulladder_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // subtraction is A + ~B + 1; cin is ignored in that mode
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[4*cnt_q +: 4] = slice_s;
        carry_d             = slice_co;
        cnt_d               = cnt_q + CW'(1);
        if (last_nib) begin
          cout_d  = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: WIDTH=16 and WIDTH=4 instances, each with
// an arithmetic reference model compared every cycle, plus directed literals.

module tb_nibble_serial_add_ctrl;
  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[NI], ordy[NI], cin_i[NI], sub_i[NI];
  logic [15:0] a_i[NI], b_i[NI];
  logic        ir[NI], ov[NI], co[NI], of[NI], bz[NI];
  logic [15:0] sm[NI];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int W = (gi == 0) ? 16 : 4;
    localparam int N = W / 4;
    logic [W-1:0] s;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[gi]),
      .in_ready  (ir[gi]),
      .a         (a_i[gi][W-1:0]),
      .b         (b_i[gi][W-1:0]),
      .cin       (cin_i[gi]),
      .sub       (sub_i[gi]),
      .out_valid (ov[gi]),
      .out_ready (ordy[gi]),
      .sum       (s),
      .cout      (co[gi]),
      .ovf       (of[gi]),
      .busy      (bz[gi])
    );
    assign sm[gi] = 16'(s);

    // reference: whole result computed at acceptance; sum reveals 4 more bits per cycle
    int           st = 0;
    int           k = 0;
    logic [W:0]   res;
    logic [W-1:0] bb, m_sum;
    logic         m_c, m_o, e_o;

    initial forever begin
      @(posedge clk);
      if (!rst_n) begin
        st = 0; k = 0; m_sum = '0; m_c = 1'b0; m_o = 1'b0;
      end else if (st == 0) begin
        if (iv[gi]) begin
          bb    = sub_i[gi] ? ~b_i[gi][W-1:0] : b_i[gi][W-1:0];
          res   = (W+1)'(a_i[gi][W-1:0]) + (W+1)'(bb) + (W+1)'(sub_i[gi] | cin_i[gi]);
          e_o   = (a_i[gi][W-1] == bb[W-1]) && (res[W-1] != a_i[gi][W-1]);
          m_sum = '0;
          k     = 0;
          st    = 1;
        end
      end else if (st == 1) begin
        k++;
        m_sum = res[W-1:0] & ~({W{1'b1}} << (4 * k));
        if (k == N) begin
          st  = 2;
          m_c = res[W];
          m_o = e_o;
        end
      end else begin
        if (ordy[gi]) st = 0;
      end
    end

    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        chk($sformatf("w%0d_in_ready", W),  32'(ir[gi]), 32'(st == 0));
        chk($sformatf("w%0d_out_valid", W), 32'(ov[gi]), 32'(st == 2));
        chk($sformatf("w%0d_busy", W),      32'(bz[gi]), 32'(st != 0));
        chk($sformatf("w%0d_sum", W),       32'(sm[gi]), 32'(m_sum));
        chk($sformatf("w%0d_cout", W),      32'(co[gi]), 32'(m_c));
        chk($sformatf("w%0d_ovf", W),       32'(of[gi]), 32'(m_o));
      end
    end
  end

  // caller is at a negedge with the instance idle; returns one negedge after acceptance
  task automatic issue(int g, logic [15:0] a, logic [15:0] b, logic c, logic s);
    iv[g] = 1'b1; a_i[g] = a; b_i[g] = b; cin_i[g] = c; sub_i[g] = s;
    @(negedge clk);
    iv[g] = 1'b0;
  endtask

  task automatic wait_valid(int g, output int k);
    k = 0;
    while (!ov[g] && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic op(int g, logic [15:0] a, logic [15:0] b, logic c, logic s,
                    logic [15:0] es, logic ec, logic eo, int lat);
    int k;
    issue(g, a, b, c, s);
    wait_valid(g, k);
    chk($sformatf("lit_latency_%0h", a), 32'(k), 32'(lat));
    chk($sformatf("lit_sum_%0h", a), 32'(sm[g]), 32'(es));
    chk($sformatf("lit_cout_%0h", a), 32'(co[g]), 32'(ec));
    chk($sformatf("lit_ovf_%0h", a), 32'(of[g]), 32'(eo));
    ordy[g] = 1'b1;
    @(negedge clk);
    ordy[g] = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; ordy[g] = 1'b0; cin_i[g] = 1'b0; sub_i[g] = 1'b0;
      a_i[g] = '0; b_i[g] = '0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_sum", 32'(sm[0]), 32'h0);
    chk("reset_in_ready", 32'(ir[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4);
    op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
    op(1, 16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1);

    // backpressure: held result, ignored operands, then back-to-back acceptance
    issue(0, 16'h1111, 16'h0001, 1'b0, 1'b0);
    wait_valid(0, k);
    chk("bp_latency", 32'(k), 32'd4);
    iv[0] = 1'b1; a_i[0] = 16'h1234; b_i[0] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(ov[0]), 32'h1);
      chk("bp_sum_held", 32'(sm[0]), 32'h1112);
      chk("bp_in_ready", 32'(ir[0]), 32'h0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_idle_in_ready", 32'(ir[0]), 32'h1);
    @(negedge clk);
    iv[0] = 1'b0;
    wait_valid(0, k);
    chk("bp_next_latency", 32'(k), 32'd4);
    chk("bp_next_sum", 32'(sm[0]), 32'h1235);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;

    // leave cout/ovf set so the reset clear is observable
    op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);
    issue(0, 16'hAAAA, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(ir[0]), 32'h1);
    chk("rst_out_valid", 32'(ov[0]), 32'h0);
    chk("rst_busy", 32'(bz[0]), 32'h0);
    chk("rst_sum", 32'(sm[0]), 32'h0);
    chk("rst_cout", 32'(co[0]), 32'h0);
    chk("rst_ovf", 32'(of[0]), 32'h0);
    op(0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 4);

    repeat (1500) begin
      for (int g = 0; g < NI; g++) begin
        iv[g]    = 1'($urandom_range(0, 1));
        a_i[g]   = 16'($urandom);
        b_i[g]   = 16'($urandom);
        cin_i[g] = 1'($urandom_range(0, 1));
        sub_i[g] = 1'($urandom_range(0, 1));
        ordy[g]  = ($urandom_range(0, 9) < 6);
      end
      rst_n = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
